// File: rtl/rotenc_ctrl_pkg.sv
// Shared types and helpers for the rotary-encoder value controller.
package rotenc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SELECT = 2'd0,
    ST_EDIT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Index width that never collapses to zero for a single channel.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/rotenc_sat_step.sv
// Combinational saturating add/subtract of one step, clamped to [VAL_MIN, VAL_MAX].
module rotenc_sat_step #(
  parameter int VAL_W   = 8,
  parameter int VAL_MIN = 0,
  parameter int VAL_MAX = 99
) (
  input  logic [VAL_W-1:0] val_i,
  input  logic [VAL_W-1:0] step_i,
  input  logic             up_i,
  output logic [VAL_W-1:0] val_o,
  output logic             changed_o
);

  localparam logic [VAL_W:0] LIM_LO = (VAL_W+1)'(VAL_MIN);
  localparam logic [VAL_W:0] LIM_HI = (VAL_W+1)'(VAL_MAX);

  logic [VAL_W:0] wide;

  always_comb begin
    if (up_i) begin
      wide = {1'b0, val_i} + {1'b0, step_i};
    end else begin
      wide = {1'b0, val_i} - {1'b0, step_i};
    end

    // The extra MSB doubles as the borrow when subtracting past zero.
    if (!up_i && wide[VAL_W]) begin
      val_o = LIM_LO[VAL_W-1:0];
    end else if (wide > LIM_HI) begin
      val_o = LIM_HI[VAL_W-1:0];
    end else if (wide < LIM_LO) begin
      val_o = LIM_LO[VAL_W-1:0];
    end else begin
      val_o = wide[VAL_W-1:0];
    end

    changed_o = (val_o != val_i);
  end

endmodule

// File: rtl/rotenc_value_ctrl.sv
// Two-level rotary-encoder UI controller: channel select, value edit with
// saturation, rate acceleration, idle timeout and a lock override.
module rotenc_value_ctrl
  import rotenc_ctrl_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int VAL_W       = 8,
  parameter int VAL_MIN     = 0,
  parameter int VAL_MAX     = 99,
  parameter int INIT_VAL    = 0,
  parameter int ACCEL_WIN   = 600000,
  parameter int ACCEL_STEP  = 10,
  parameter int TIMEOUT_CYC = 60000000
) (
  input  logic                            sys_clk,
  input  logic                            rst_n,
  input  logic                            enc_cw,
  input  logic                            enc_ccw,
  input  logic                            btn_press,
  input  logic                            lock,
  output logic                            enc_en,
  output logic                            enc_clear,
  output logic [clog2_min1(N_CH)-1:0]     sel_idx,
  output logic                            edit_mode,
  output logic [N_CH*VAL_W-1:0]           val_flat,
  output logic                            upd_strobe,
  output logic [clog2_min1(N_CH)-1:0]     upd_idx
);

  localparam int unsigned IDX_W = clog2_min1(N_CH);
  localparam int unsigned GAP_W = clog2_min1(ACCEL_WIN + 1);
  localparam int unsigned TO_W  = clog2_min1(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CH - 1);
  localparam logic [GAP_W-1:0] GAP_SAT   = GAP_W'(ACCEL_WIN);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [VAL_W-1:0] STEP_FAST = VAL_W'(ACCEL_STEP);
  localparam logic [VAL_W-1:0] STEP_ONE  = VAL_W'(1);
  localparam logic [VAL_W-1:0] RST_VAL   = VAL_W'(INIT_VAL);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               first_q, first_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               en_q, en_d;
  logic               clear_q, clear_d;
  logic               edit_q, edit_d;
  logic               strobe_q, strobe_d;
  logic [IDX_W-1:0]   upd_idx_q, upd_idx_d;
  logic [VAL_W-1:0]   val_q [N_CH];
  logic [VAL_W-1:0]   val_d [N_CH];

  logic               cw_evt, ccw_evt, det_evt;
  logic [VAL_W-1:0]   step;
  logic [VAL_W-1:0]   new_val;
  logic               val_changed;

  // A button in the same cycle swallows the detent.
  assign cw_evt  = enc_cw & ~enc_ccw & ~btn_press;
  assign ccw_evt = enc_ccw & ~enc_cw & ~btn_press;
  assign det_evt = cw_evt | ccw_evt;

  assign step = (first_q || (gap_q >= GAP_SAT)) ? STEP_ONE : STEP_FAST;

  rotenc_sat_step #(
    .VAL_W   (VAL_W),
    .VAL_MIN (VAL_MIN),
    .VAL_MAX (VAL_MAX)
  ) u_sat_step (
    .val_i     (val_q[sel_q]),
    .step_i    (step),
    .up_i      (cw_evt),
    .val_o     (new_val),
    .changed_o (val_changed)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    first_d   = first_q;
    gap_d     = gap_q;
    to_d      = to_q;
    clear_d   = 1'b0;
    strobe_d  = 1'b0;
    upd_idx_d = upd_idx_q;
    val_d     = val_q;

    if (lock) begin
      state_d = ST_LOCKED;
    end else begin
      case (state_q)
        ST_LOCKED: begin
          state_d = ST_SELECT;
          clear_d = 1'b1;
        end

        ST_SELECT: begin
          if (btn_press) begin
            state_d = ST_EDIT;
            clear_d = 1'b1;
            first_d = 1'b1;
            gap_d   = '0;
            to_d    = '0;
          end else if (cw_evt) begin
            sel_d = (sel_q == IDX_LAST) ? '0 : sel_q + 1'b1;
          end else if (ccw_evt) begin
            sel_d = (sel_q == '0) ? IDX_LAST : sel_q - 1'b1;
          end
        end

        ST_EDIT: begin
          if (btn_press) begin
            state_d = ST_SELECT;
            clear_d = 1'b1;
            to_d    = '0;
          end else begin
            if (det_evt) begin
              val_d[sel_q] = new_val;
              strobe_d     = val_changed;
              if (val_changed) begin
                upd_idx_d = sel_q;
              end
              first_d = 1'b0;
              gap_d   = '0;
              to_d    = '0;
            end else begin
              if (gap_q != GAP_SAT) begin
                gap_d = gap_q + 1'b1;
              end
              to_d = to_q + 1'b1;
            end
            // Timeout still exits even when a detent lands in the same cycle.
            if (to_q == TO_LAST) begin
              state_d = ST_SELECT;
              clear_d = 1'b1;
              to_d    = '0;
            end
          end
        end

        default: begin
          state_d = ST_SELECT;
        end
      endcase
    end

    en_d   = (state_d != ST_LOCKED);
    edit_d = (state_d == ST_EDIT);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SELECT;
      sel_q     <= '0;
      first_q   <= 1'b0;
      gap_q     <= '0;
      to_q      <= '0;
      en_q      <= 1'b0;
      clear_q   <= 1'b0;
      edit_q    <= 1'b0;
      strobe_q  <= 1'b0;
      upd_idx_q <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        val_q[k] <= RST_VAL;
      end
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      first_q   <= first_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
      en_q      <= en_d;
      clear_q   <= clear_d;
      edit_q    <= edit_d;
      strobe_q  <= strobe_d;
      upd_idx_q <= upd_idx_d;
      val_q     <= val_d;
    end
  end

  always_comb begin
    val_flat = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      val_flat[k*VAL_W +: VAL_W] = val_q[k];
    end
  end

  assign enc_en     = en_q;
  assign enc_clear  = clear_q;
  assign sel_idx    = sel_q;
  assign edit_mode  = edit_q;
  assign upd_strobe = strobe_q;
  assign upd_idx    = upd_idx_q;

endmodule
